// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU operation sequencer: FSM state encoding and ALU function codes.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_F,
    EXEC,
    RESP
  } seq_state_e;

  localparam logic [2:0] FXN_PASS_A = 3'b000;
  localparam logic [2:0] FXN_PASS_B = 3'b001;
  localparam logic [2:0] FXN_NEG_A  = 3'b010;
  localparam logic [2:0] FXN_NEG_B  = 3'b011;
  localparam logic [2:0] FXN_A_LT_B = 3'b100;
  localparam logic [2:0] FXN_XNOR   = 3'b101;
  localparam logic [2:0] FXN_ADD    = 3'b110;
  localparam logic [2:0] FXN_SUB    = 3'b111;

endpackage

// File: rtl/alu_settle_counter.sv
// Counts clock edges while the ALU inputs settle.
// The terminal-count pulse is asserted on the last edge of the window.
module alu_settle_counter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == LAST);

  // Wraps to zero on terminal count so the next EXEC starts clean.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Loads A, B and fxn from a word stream, drives a combinational ALU for a settle window,
// then offers the captured result/flags on a valid/ready result stream.
module alu_op_sequencer #(
  parameter int WIDTH         = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       alu_fxn,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic [WIDTH-1:0] res_data,
  output logic             res_c,
  output logic             res_v,
  output logic [2:0]       res_fxn,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  import alu_seq_pkg::*;

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       fxn_q, fxn_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_c_q, res_c_d;
  logic             res_v_q, res_v_d;
  logic [2:0]       res_fxn_q, res_fxn_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;

  logic settle_en;
  logic settle_tc;
  logic in_xfer;

  // abort also clears the counter so a later EXEC always starts from zero.
  assign settle_en = (state_q == EXEC) && !abort;
  assign in_xfer   = in_valid && in_ready_q;

  alu_settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(!settle_en),
    .en   (settle_en),
    .tc   (settle_tc)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    fxn_d      = fxn_q;
    res_data_d = res_data_q;
    res_c_d    = res_c_q;
    res_v_d    = res_v_q;
    res_fxn_d  = res_fxn_q;
    if (abort) begin
      state_d = LOAD_A;
    end else begin
      case (state_q)
        LOAD_A: if (in_xfer) begin
          a_d     = in_data;
          state_d = LOAD_B;
        end
        LOAD_B: if (in_xfer) begin
          b_d     = in_data;
          state_d = LOAD_F;
        end
        LOAD_F: if (in_xfer) begin
          fxn_d   = in_data[2:0];
          state_d = EXEC;
        end
        EXEC: if (settle_tc) begin
          res_data_d = alu_out;
          res_c_d    = alu_c;
          res_v_d    = alu_v;
          res_fxn_d  = fxn_q;
          state_d    = RESP;
        end
        RESP: if (res_ready) begin
          state_d = LOAD_A;
        end
        default: state_d = LOAD_A;
      endcase
    end
    // Handshake outputs are registered, so they are decoded from the next state.
    res_valid_d = (state_d == RESP);
    busy_d      = (state_d == EXEC) || (state_d == RESP);
    in_ready_d  = !busy_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      fxn_q       <= '0;
      res_data_q  <= '0;
      res_c_q     <= 1'b0;
      res_v_q     <= 1'b0;
      res_fxn_q   <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fxn_q       <= fxn_d;
      res_data_q  <= res_data_d;
      res_c_q     <= res_c_d;
      res_v_q     <= res_v_d;
      res_fxn_q   <= res_fxn_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_fxn   = fxn_q;
  assign res_data  = res_data_q;
  assign res_c     = res_c_q;
  assign res_v     = res_v_q;
  assign res_fxn   = res_fxn_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus a random stream, with a 6-bit ALU as responder
// and an integer-arithmetic reference model fed by a word/result monitor.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int W = 6;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         abort = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   alu_fxn;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic         alu_c, alu_v;
  logic [W-1:0] res_data;
  logic         res_c, res_v;
  logic [2:0]   res_fxn;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int n_res = 0;

  logic [W-1:0] part_q[$];
  logic [10:0]  exp_q[$];
  logic [10:0]  mon_e;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .alu_fxn(alu_fxn), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v),
    .res_data(res_data), .res_c(res_c), .res_v(res_v), .res_fxn(res_fxn),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  // Combinational ALU acting as the responder.
  logic [W:0] alu_tmp;
  always_comb begin
    alu_tmp = '0;
    alu_out = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_fxn)
      FXN_PASS_A: alu_out = alu_a;
      FXN_PASS_B: alu_out = alu_b;
      FXN_NEG_A:  alu_out = ~alu_a + 1'b1;
      FXN_NEG_B:  alu_out = ~alu_b + 1'b1;
      FXN_A_LT_B: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 6'd1 : 6'd0;
      FXN_XNOR:   alu_out = ~(alu_a ^ alu_b);
      FXN_ADD: begin
        alu_tmp = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = alu_tmp[W-1:0];
        alu_c   = alu_tmp[W];
        alu_v   = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
      end
      default: begin
        alu_tmp = {1'b0, alu_a} + {1'b0, ~alu_b} + 7'd1;
        alu_out = alu_tmp[W-1:0];
        alu_c   = alu_tmp[W];
        alu_v   = (alu_a[W-1] != alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
      end
    endcase
  end

  // Reference result as {fxn, c, v, out}, from plain integer arithmetic on the operands.
  function automatic logic [10:0] ref_alu(input logic [5:0] a, input logic [5:0] b, input logic [2:0] f);
    int ua, ub, sa, sb, s, o;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32) ? ua - 64 : ua;
    sb = (ub >= 32) ? ub - 64 : ub;
    c = 1'b0;
    v = 1'b0;
    s = 0;
    case (f)
      3'd0: o = ua;
      3'd1: o = ub;
      3'd2: o = (64 - ua) % 64;
      3'd3: o = (64 - ub) % 64;
      3'd4: o = (sa < sb) ? 1 : 0;
      3'd5: o = 63 - (ua ^ ub);
      3'd6: begin
        s = ua + ub;
        o = s % 64;
        c = (s >= 64);
        v = ((sa + sb) > 31) || ((sa + sb) < -32);
      end
      default: begin
        s = ua - ub;
        o = (s + 64) % 64;
        c = (ua >= ub);
        v = ((sa - sb) > 31) || ((sa - sb) < -32);
      end
    endcase
    return {f, c, v, o[5:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: tracks accepted words and checks every result handshake against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      part_q.delete();
      exp_q.delete();
    end else begin
      if (busy) chk("in_ready_low_while_busy", {31'd0, in_ready}, 32'd0);
      if (abort) begin
        part_q.delete();
        if (busy && exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        if (in_valid && in_ready) begin
          part_q.push_back(in_data);
          if (part_q.size() == 3) begin
            exp_q.push_back(ref_alu(part_q[0], part_q[1], part_q[2][2:0]));
            part_q.delete();
          end
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("result_vs_model", {21'd0, res_fxn, res_c, res_v, res_data}, {21'd0, mon_e});
            n_res++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    int t;
    in_data  = w;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) chk("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] f);
    send(a);
    send(b);
    send(f);
  endtask

  task automatic wait_res();
    int t;
    t = 0;
    while (!res_valid && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) chk("result_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hold_d;
    logic [4:0]   hold_f;
    logic [W-1:0] w6[6];
    logic [W-1:0] rw[90];
    int idx, base, t;
    logic x;

    // Reset
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_alu_a", {26'd0, alu_a}, 32'd0);
    chk("rst_res_data", {26'd0, res_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: ADD 5+3, latency check
    res_ready = 1'b1;
    cmd(6'd5, 6'd3, 6'b000110);
    chk("t1_valid_edge0", {31'd0, res_valid}, 32'd0);
    chk("t1_busy_exec", {31'd0, busy}, 32'd1);
    chk("t1_in_ready_exec", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t1_valid_edge1", {31'd0, res_valid}, 32'd0);
    tick();
    chk("t1_valid_edge2", {31'd0, res_valid}, 32'd1);
    chk("t1_data", {26'd0, res_data}, 32'd8);
    chk("t1_c", {31'd0, res_c}, 32'd0);
    chk("t1_v", {31'd0, res_v}, 32'd0);
    chk("t1_fxn", {29'd0, res_fxn}, 32'd6);
    tick();
    chk("t1_resp_one_cycle", {31'd0, res_valid}, 32'd0);
    chk("t1_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("t1_res_held", {26'd0, res_data}, 32'd8);

    // 2: ADD overflow, SUB wrap
    cmd(6'd31, 6'd1, 6'b000110);
    wait_res();
    chk("t2_add_data", {26'd0, res_data}, 32'd32);
    chk("t2_add_v", {31'd0, res_v}, 32'd1);
    tick();
    cmd(6'd1, 6'd2, 6'b000111);
    wait_res();
    chk("t2_sub_data", {26'd0, res_data}, 32'd63);
    chk("t2_sub_v", {31'd0, res_v}, 32'd0);
    chk("t2_sub_c", {31'd0, res_c}, 32'd0);
    tick();

    // 3: result back-pressure, upper fxn bits ignored
    res_ready = 1'b0;
    cmd(6'd20, 6'd45, 6'b101101);
    wait_res();
    hold_d = res_data;
    hold_f = {res_fxn, res_c, res_v};
    chk("t3_xnor", {26'd0, res_data}, 32'd6);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_valid_held", {31'd0, res_valid}, 32'd1);
      chk("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("t3_data_stable", {26'd0, res_data}, {26'd0, hold_d});
      chk("t3_flags_stable", {27'd0, res_fxn, res_c, res_v}, {27'd0, hold_f});
    end
    res_ready = 1'b1;
    tick();
    chk("t3_valid_drop", {31'd0, res_valid}, 32'd0);
    chk("t3_in_ready_back", {31'd0, in_ready}, 32'd1);

    // 4: abort after A transfer
    send(6'd9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_alu_a_kept", {26'd0, alu_a}, 32'd9);
    chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
    cmd(6'd7, 6'd2, 6'b000001);
    wait_res();
    chk("t4_data", {26'd0, res_data}, 32'd2);
    chk("t4_alu_a", {26'd0, alu_a}, 32'd7);
    tick();

    // 5: reset during EXEC
    cmd(6'd10, 6'd20, 6'b000110);
    rst_n = 1'b0;
    #1;
    chk("t5_res_valid", {31'd0, res_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_alu_a", {26'd0, alu_a}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    cmd(6'd12, 6'd3, 6'b000111);
    wait_res();
    chk("t5_after_data", {26'd0, res_data}, 32'd9);
    tick();

    // 6: continuous in_valid with 6 queued words
    w6[0] = 6'd3;  w6[1] = 6'd4;  w6[2] = 6'd6;
    w6[3] = 6'd40; w6[4] = 6'd17; w6[5] = 6'd7;
    base = n_res;
    idx = 0;
    in_valid = 1'b1;
    in_data = w6[0];
    for (int c = 0; c < 200 && idx < 6; c++) begin
      x = in_ready;
      tick();
      if (x) begin
        idx++;
        if (idx < 6) in_data = w6[idx];
      end
    end
    in_valid = 1'b0;
    chk("t6_words_taken", idx, 32'd6);
    t = 0;
    while (n_res < base + 2 && t < 100) begin
      tick();
      t++;
    end
    chk("t6_results", n_res - base, 32'd2);

    // Random stream with random back-pressure
    for (int i = 0; i < 90; i++) rw[i] = W'($urandom_range(0, 63));
    base = n_res;
    idx = 0;
    in_data = rw[0];
    for (int c = 0; c < 3000 && idx < 90; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 1) != 0);
      x = in_valid && in_ready;
      tick();
      if (x) begin
        idx++;
        if (idx < 90) in_data = rw[idx];
      end
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    t = 0;
    while (n_res < base + 30 && t < 100) begin
      tick();
      t++;
    end
    chk("rand_words_taken", idx, 32'd90);
    chk("rand_results", n_res - base, 32'd30);
    tick();
    chk("end_exp_empty", exp_q.size(), 32'd0);
    chk("end_part_empty", part_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
